// File: rtl/spi_reg_master.sv
// Host-side SPI mode-0 master: turns one register command into a 32-bit
// frame {rw_mode, addr, data} and returns read data on a one-cycle strobe.
module spi_reg_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TURN_CYC  = 8,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [13:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        SCLK,
  output logic        MOSI,
  output logic        SS,
  input  logic        MISO
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_TURN, S_HOLD, S_RESP, S_GAP
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [5:0]    r_bit, w_bit;
  logic [31:0]   r_sr, w_sr;
  logic [15:0]   r_rd_sr, w_rd_sr;
  logic [15:0]   r_rdata, w_rdata;
  logic          r_write, w_write;
  logic          r_sclk, w_sclk;
  logic          r_mosi, w_mosi;
  logic          r_ss, w_ss;
  logic          r_rsp_valid, w_rsp_valid;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt + CW'(1);
    w_bit       = r_bit;
    w_sr        = r_sr;
    w_rd_sr     = r_rd_sr;
    w_rdata     = r_rdata;
    w_write     = r_write;
    w_sclk      = r_sclk;
    w_mosi      = r_mosi;
    w_ss        = r_ss;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (cmd_valid) begin
          w_state = S_SETUP;
          w_sr    = {1'b0, cmd_write, cmd_addr, (cmd_write ? cmd_wdata : 16'h0000)};
          w_write = cmd_write;
          w_mosi  = w_sr[31];
          w_ss    = 1'b0;
          w_sclk  = 1'b0;
          w_bit   = '0;
        end
      end
      S_SETUP: begin
        if (r_cnt == CW'(SETUP_CYC - 1)) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(CLK_DIV - 1)) begin
          w_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
            w_bit  = r_bit + 6'd1;
            // rising edges 17..32 carry the read data
            if (!r_write && (r_bit >= 6'd16)) w_rd_sr = {r_rd_sr[14:0], MISO};
          end else begin
            w_sclk = 1'b0;
            if (r_bit == 6'd32) begin
              w_state = S_HOLD;
              w_mosi  = 1'b0;
            end else begin
              w_sr   = {r_sr[30:0], 1'b0};
              w_mosi = r_sr[30];
              if (!r_write && (r_bit == 6'd16) && (TURN_CYC != 0)) begin
                w_state = S_TURN;
                w_mosi  = 1'b0;
              end
            end
          end
        end
      end
      S_TURN: begin
        if (r_cnt == CW'(TURN_CYC - 1)) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_mosi  = r_sr[31];
        end
      end
      S_HOLD: begin
        if (r_cnt == CW'(HOLD_CYC - 1)) begin
          w_state     = S_RESP;
          w_cnt       = '0;
          w_ss        = 1'b1;
          w_rsp_valid = 1'b1;
          if (!r_write) w_rdata = r_rd_sr;
        end
      end
      S_RESP: begin
        w_state = S_GAP;
        w_cnt   = '0;
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sr        <= '0;
      r_rd_sr     <= '0;
      r_rdata     <= '0;
      r_write     <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss        <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit       <= w_bit;
      r_sr        <= w_sr;
      r_rd_sr     <= w_rd_sr;
      r_rdata     <= w_rdata;
      r_write     <= w_write;
      r_sclk      <= w_sclk;
      r_mosi      <= w_mosi;
      r_ss        <= w_ss;
      r_rsp_valid <= w_rsp_valid;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign SCLK      = r_sclk;
  assign MOSI      = r_mosi;
  assign SS        = r_ss;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: two instances (default timing, and CLK_DIV=2 /
// TURN_CYC=0) driven by directed and random commands against a pin-level slave model.
module tb_spi_reg_master;

  localparam int unsigned SETUP = 2, HOLD = 2, GAP = 4;
  localparam int unsigned DIV0 = 4, TURN0 = 8, DIV1 = 2, TURN1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        cmd_valid[2];
  logic        cmd_write[2];
  logic [13:0] cmd_addr[2];
  logic [15:0] cmd_wdata[2];
  logic        miso[2];
  logic [1:0]  cmd_ready, rsp_valid, busy, sclk, mosi, ss;
  logic [1:0][15:0] rsp_rdata;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_reg_master #(
      .CLK_DIV  (g == 0 ? DIV0 : DIV1),
      .SETUP_CYC(SETUP),
      .HOLD_CYC (HOLD),
      .TURN_CYC (g == 0 ? TURN0 : TURN1),
      .GAP_CYC  (GAP)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_write(cmd_write[g]),
      .cmd_addr (cmd_addr[g]),
      .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .SCLK     (sclk[g]),
      .MOSI     (mosi[g]),
      .SS       (ss[g]),
      .MISO     (miso[g])
    );
  end

  // Pin-level observer and SPI slave, sampled on the falling clk edge.
  int          cyc = 0;
  logic [15:0] slave_data[2];
  logic        p_sclk[2], p_ss[2], p_rdy[2];
  logic [31:0] m_frame[2];
  int m_rises[2], m_falls[2], m_run[2], m_sslow[2], m_acc_cyc[2], m_acc_cnt[2];
  int m_rsp_cyc[2], m_rsp_cnt[2], m_rise_ss[2], m_fall_ss[2];
  int m_t16[2], m_t17[2], m_last[2], m_pmin[2], m_pmax[2], m_viol[2], m_rdy_cnt[2];
  logic [15:0] m_rsp_data[2];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      miso[g] = 1'b0; m_acc_cnt[g] = 0; m_rsp_cnt[g] = 0; m_viol[g] = 0; m_rdy_cnt[g] = 0;
      m_rises[g] = 0; m_falls[g] = 0; m_run[g] = 0; m_frame[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (ss[g] == 1'b0 && p_ss[g] == 1'b1) begin
          m_fall_ss[g] = cyc; m_run[g] = 0; m_rises[g] = 0; m_falls[g] = 0;
          m_frame[g] = '0; m_pmin[g] = 1 << 30; m_pmax[g] = 0;
        end
        if (ss[g] == 1'b0) m_run[g]++;
        if (ss[g] == 1'b1 && p_ss[g] == 1'b0) begin
          m_rise_ss[g] = cyc; m_sslow[g] = m_run[g];
        end
        if (sclk[g] == 1'b1 && p_sclk[g] == 1'b0) begin
          m_rises[g]++;
          m_frame[g] = {m_frame[g][30:0], mosi[g]};
          if (m_rises[g] > 1) begin
            if (cyc - m_last[g] < m_pmin[g]) m_pmin[g] = cyc - m_last[g];
            if (cyc - m_last[g] > m_pmax[g]) m_pmax[g] = cyc - m_last[g];
          end
          m_last[g] = cyc;
          if (m_rises[g] == 16) m_t16[g] = cyc;
          if (m_rises[g] == 17) m_t17[g] = cyc;
        end
        if (sclk[g] == 1'b0 && p_sclk[g] == 1'b1) begin
          m_falls[g]++;
          if (m_falls[g] >= 16 && m_falls[g] <= 31) miso[g] = slave_data[g][31 - m_falls[g]];
          else miso[g] = 1'($urandom);
        end
        if (sclk[g] == 1'b1 && ss[g] == 1'b1) m_viol[g]++;
        if (cmd_ready[g] == 1'b1 && (rsp_valid[g] == 1'b1 || ss[g] == 1'b0)) m_viol[g]++;
        if (p_rdy[g] == 1'b1 && cmd_ready[g] == 1'b0) begin
          m_acc_cnt[g]++; m_acc_cyc[g] = cyc - 1;
        end
        if (cmd_ready[g] == 1'b1) m_rdy_cnt[g]++;
        if (rsp_valid[g] == 1'b1) begin
          m_rsp_cnt[g]++; m_rsp_cyc[g] = cyc; m_rsp_data[g] = rsp_rdata[g];
        end
        p_sclk[g] = sclk[g]; p_ss[g] = ss[g]; p_rdy[g] = cmd_ready[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "global timeout");
  end

  // Reference model and directed/random stimulus.
  int n_assert = 0, n_fail = 0;
  logic [15:0] exp_rdata[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int unsigned ss_low_len(input int g, input logic wr);
    return SETUP + 64 * div_of(g) + HOLD + (wr ? 0 : ((g == 0) ? TURN0 : TURN1));
  endfunction

  task automatic wait_ready(input int g);
    int k = 0;
    @(negedge clk);
    while (cmd_ready[g] !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'b0, cmd_ready[g]}, 32'd1);
  endtask

  task automatic send(input int g, input logic wr, input logic [13:0] a, input logic [15:0] d);
    wait_ready(g);
    cmd_valid[g] = 1'b1; cmd_write[g] = wr; cmd_addr[g] = a;
    cmd_wdata[g] = wr ? d : 16'($urandom);
    @(negedge clk);
    cmd_valid[g] = 1'b0; cmd_addr[g] = 14'($urandom); cmd_wdata[g] = 16'($urandom);
  endtask

  task automatic finish(input int g, input logic wr, input logic [13:0] a, input logic [15:0] d,
                        input int n0);
    int k = 0;
    while (m_rsp_cnt[g] == n0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rsp_seen", m_rsp_cnt[g], n0 + 1);
    if (!wr) exp_rdata[g] = slave_data[g];
    chk("frame", m_frame[g], {1'b0, wr, a, (wr ? d : 16'h0000)});
    chk("rises", m_rises[g], 32);
    chk("ss_low", m_sslow[g], ss_low_len(g, wr));
    chk("rsp_latency", m_rsp_cyc[g] - m_acc_cyc[g], ss_low_len(g, wr) + 1);
    chk("rsp_rdata", {16'h0, m_rsp_data[g]}, {16'h0, exp_rdata[g]});
    chk("turn_gap", m_t17[g] - m_t16[g], 2 * div_of(g) + (wr ? 0 : ((g == 0) ? TURN0 : TURN1)));
    chk("sclk_pmin", m_pmin[g], 2 * div_of(g));
    chk("protocol_viol", m_viol[g], 0);
  endtask

  task automatic do_frame(input int g, input logic wr, input logic [13:0] a, input logic [15:0] d,
                          input logic [15:0] sd);
    int n0;
    slave_data[g] = sd;
    n0 = m_rsp_cnt[g];
    send(g, wr, a, d);
    finish(g, wr, a, d, n0);
  endtask

  initial begin
    int n0, a0, r0, k;
    logic [13:0] a;
    logic [15:0] d;
    logic wr;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; cmd_valid[g] = 1'b0; cmd_write[g] = 1'b0;
      cmd_addr[g] = '0; cmd_wdata[g] = '0; exp_rdata[g] = '0; slave_data[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ss", {31'b0, ss[g]}, 32'd1);
      chk("rst_sclk_mosi", {30'b0, sclk[g], mosi[g]}, 32'd0);
      chk("rst_ready_busy", {30'b0, cmd_ready[g], busy[g]}, 32'd2);
      chk("rst_rsp", {15'b0, rsp_valid[g], rsp_rdata[g]}, 32'd0);
      rst[g] = 1'b0;
    end

    // Write and read with default timing
    do_frame(0, 1'b1, 14'h0201, 16'hA5C3, 16'($urandom));
    do_frame(0, 1'b0, 14'h0004, 16'h0000, 16'h1234);

    // Back-to-back writes with cmd_valid held high
    n0 = m_rsp_cnt[0]; a0 = m_acc_cnt[0];
    slave_data[0] = 16'($urandom);
    wait_ready(0);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 14'h1ABC; cmd_wdata[0] = 16'h5A5A;
    @(negedge clk); #1;
    r0 = m_rdy_cnt[0];
    cmd_addr[0] = 14'h0123; cmd_wdata[0] = 16'hC0DE;
    finish(0, 1'b1, 14'h1ABC, 16'h5A5A, n0);
    k = 0;
    while (m_acc_cnt[0] != a0 + 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    cmd_valid[0] = 1'b0;
    chk("b2b_accepts", m_acc_cnt[0], a0 + 2);
    chk("b2b_ss_gap", m_fall_ss[0] - m_rise_ss[0], GAP + 2);
    chk("b2b_ready_cycles", m_rdy_cnt[0] - r0, 1);
    finish(0, 1'b1, 14'h0123, 16'hC0DE, n0 + 1);

    // Reset at the 10th SCLK rise of a read
    slave_data[0] = 16'hBEEF;
    n0 = m_rsp_cnt[0];
    send(0, 1'b0, 14'h0777, 16'h0000);
    k = 0;
    while (m_rises[0] != 10 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rise10_seen", m_rises[0], 10);
    rst[0] = 1'b1;
    @(negedge clk); #1;
    chk("midrst_ss_sclk_mosi", {29'b0, ss[0], sclk[0], mosi[0]}, 32'd4);
    chk("midrst_rsp", {15'b0, rsp_valid[0], rsp_rdata[0]}, 32'd0);
    chk("midrst_ready", {31'b0, cmd_ready[0]}, 32'd1);
    rst[0] = 1'b0;
    exp_rdata[0] = '0;
    repeat (300) @(negedge clk);
    #1;
    chk("midrst_no_rsp", m_rsp_cnt[0], n0);
    do_frame(0, 1'b0, 14'h2A5B, 16'h0000, 16'($urandom));

    // Fast instance: all-ones then all-zeros read, then a write
    do_frame(1, 1'b0, 14'($urandom), 16'h0000, 16'hFFFF);
    do_frame(1, 1'b0, 14'($urandom), 16'h0000, 16'h0000);
    do_frame(1, 1'b1, 14'($urandom), 16'($urandom), 16'hFFFF);
    chk("fast_sclk_pmax", m_pmax[1], 2 * DIV1);

    // cmd_valid toggling while busy is ignored
    slave_data[0] = 16'($urandom);
    n0 = m_rsp_cnt[0]; a0 = m_acc_cnt[0];
    send(0, 1'b0, 14'h3C3C, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      cmd_valid[0] = ~cmd_valid[0]; cmd_write[0] = 1'($urandom);
      cmd_addr[0] = 14'($urandom); cmd_wdata[0] = 16'($urandom);
      @(negedge clk);
    end
    cmd_valid[0] = 1'b0;
    finish(0, 1'b0, 14'h3C3C, 16'h0000, n0);
    chk("busy_accepts", m_acc_cnt[0], a0 + 1);

    // Random commands on both instances
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom); a = 14'($urandom); d = 16'($urandom);
      do_frame(i % 2, wr, a, d, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
